// File: rtl/n64_pkg.sv
// Shared types and timing constants for the N64 controller line PHY.
// Durations are in microseconds and are scaled by CYCLES_PER_US inside the PHY.
package n64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_TX_BIT       = 3'd1,
    ST_TX_STOP      = 3'd2,
    ST_RX_WAIT_FALL = 3'd3,
    ST_RX_SAMPLE    = 3'd4,
    ST_RX_WAIT_RISE = 3'd5,
    ST_FINISH       = 3'd6
  } n64_state_e;

  localparam int unsigned SHORT_LOW_US = 1;
  localparam int unsigned LONG_LOW_US  = 3;
  localparam int unsigned BIT_US       = 4;
  localparam int unsigned STOP_US      = 3;
  localparam int unsigned SAMPLE_US    = 2;
  localparam int unsigned MAX_RX_BITS  = 32;
  localparam int unsigned LEN_W        = 6;
  localparam int unsigned CMD_BITS     = 8;

  // Out-of-range response lengths collapse to a full 32-bit response.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_W'(MAX_RX_BITS)) return LEN_W'(MAX_RX_BITS);
    return len;
  endfunction

endpackage

// File: rtl/n64_pin_sync.sv
// Two-flop synchronizer for the controller data line plus falling-edge detect.
// All flops reset to 1 so the idle (pulled-up) line never shows a false edge.
module n64_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic line,
  output logic fall_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = pin_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line   = sync_q;
  assign fall_c = prev_q & ~sync_q;

endmodule

// File: rtl/n64_line_phy.sv
// N64 controller line PHY: sends an 8-bit command on the open-drain line,
// then collects a response of rx_len bits with a gap timeout.
module n64_line_phy
  import n64_pkg::*;
#(
  parameter int unsigned CYCLES_PER_US = 100,
  parameter int unsigned TIMEOUT_US    = 100
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        start,
  input  logic [7:0]  cmd_byte,
  input  logic [5:0]  rx_len,
  input  logic        pin_in,
  output logic        pin_oe,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rx_data
);

  localparam int unsigned SHORT_CYC  = SHORT_LOW_US * CYCLES_PER_US;
  localparam int unsigned LONG_CYC   = LONG_LOW_US * CYCLES_PER_US;
  localparam int unsigned BIT_CYC    = BIT_US * CYCLES_PER_US;
  localparam int unsigned STOP_CYC   = STOP_US * CYCLES_PER_US;
  localparam int unsigned SAMPLE_CYC = SAMPLE_US * CYCLES_PER_US;
  localparam int unsigned TO_CYC     = TIMEOUT_US * CYCLES_PER_US;
  localparam int unsigned MAX_CYC    = (TO_CYC > BIT_CYC) ? TO_CYC : BIT_CYC;
  localparam int unsigned CNT_W      = $clog2(MAX_CYC + 1);

  n64_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  bits_q, bits_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [31:0]       rx_data_q, rx_data_d;
  logic              pin_oe_q, pin_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              line;
  logic              fall_c;

  n64_pin_sync u_sync (
    .clk    (PCLK),
    .rst_n  (PRESERN),
    .pin_in (pin_in),
    .line   (line),
    .fall_c (fall_c)
  );

  // pin_oe_d is derived from the post-increment count so the registered
  // output lines up with the cycle that count describes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    len_d     = len_q;
    cmd_d     = cmd_q;
    rx_data_d = rx_data_q;
    pin_oe_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          cmd_d     = cmd_byte;
          len_d     = eff_len(rx_len);
          rx_data_d = '0;
          cnt_d     = '0;
          bits_d    = '0;
          busy_d    = 1'b1;
          pin_oe_d  = 1'b1;
          state_d   = ST_TX_BIT;
        end
      end
      ST_TX_BIT: begin
        pin_oe_d = 1'b1;
        if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
          cnt_d = '0;
          if (bits_q == LEN_W'(CMD_BITS - 1)) begin
            bits_d  = '0;
            state_d = ST_TX_STOP;
          end else begin
            bits_d = bits_q + LEN_W'(1);
            cmd_d  = {cmd_q[6:0], 1'b0};
          end
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          pin_oe_d = cnt_d < (cmd_q[7] ? CNT_W'(SHORT_CYC) : CNT_W'(LONG_CYC));
        end
      end
      ST_TX_STOP: begin
        if (cnt_q == CNT_W'(STOP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_RX_WAIT_FALL;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          pin_oe_d = cnt_d < CNT_W'(SHORT_CYC);
        end
      end
      ST_RX_WAIT_FALL: begin
        if (fall_c) begin
          cnt_d   = '0;
          state_d = ST_RX_SAMPLE;
        end else if (cnt_q == CNT_W'(TO_CYC - 1)) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RX_SAMPLE: begin
        if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
          rx_data_d = {rx_data_q[30:0], line};
          bits_d    = bits_q + LEN_W'(1);
          cnt_d     = '0;
          state_d   = ST_RX_WAIT_RISE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RX_WAIT_RISE: begin
        if (line) begin
          cnt_d   = '0;
          state_d = (bits_q == len_q) ? ST_FINISH : ST_RX_WAIT_FALL;
        end else if (cnt_q == CNT_W'(TO_CYC - 1)) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      len_q     <= '0;
      cmd_q     <= '0;
      rx_data_q <= '0;
      pin_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      len_q     <= len_d;
      cmd_q     <= cmd_d;
      rx_data_q <= rx_data_d;
      pin_oe_q  <= pin_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign pin_oe  = pin_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign rx_data = rx_data_q;

endmodule

// File: doc/n64_line_phy.md
N64_LINE_PHY -- requirements
Module: n64_line_phy

Interface
REQ-001 Parameter CYCLES_PER_US, default 100, gives PCLK cycles per microsecond; it SHALL be at least 8.
REQ-002 Parameter TIMEOUT_US, default 100, is the response-gap timeout in microseconds.
REQ-003 PCLK  in  1  the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 PRESERN  in  1  reset, synchronous and active-low.
REQ-005 start  in  1  one-cycle request to run a transaction.
REQ-006 cmd_byte  in  8  command byte, sent MSB first.
REQ-007 rx_len  in  6  number of response bits expected, legal range 1..32.
REQ-008 pin_in  in  1  asynchronous sample of the controller data line.
REQ-009 pin_oe  out  1  1 = pull the line low; 0 = release the line (the pull-up idles it high).
REQ-010 busy  out  1  a transaction is in progress.
REQ-011 done  out  1  one-cycle pulse: all rx_len bits were received.
REQ-012 timeout  out  1  one-cycle pulse: the response was aborted.
REQ-013 rx_data  out  32  received bits, right-aligned; the last bit received is at bit 0.

Function
REQ-014 The FSM SHALL use the states IDLE, TX_BIT, TX_STOP, RX_WAIT_FALL, RX_SAMPLE, RX_WAIT_RISE and FINISH.
REQ-015 In IDLE, when start=1, the block SHALL latch cmd_byte and rx_len, clear rx_data to 0, set busy the next cycle and enter TX_BIT.
REQ-016 start SHALL be ignored whenever busy=1.
REQ-017 TX_BIT timing per bit:
- each bit lasts exactly 4*CYCLES_PER_US cycles;
- a '0' bit holds pin_oe=1 for 3 us, then pin_oe=0 for 1 us;
- a '1' bit holds pin_oe=1 for 1 us, then pin_oe=0 for 3 us;
- 8 bits SHALL be sent.
REQ-018 TX_STOP SHALL hold pin_oe=1 for 1 us, then pin_oe=0 for 2 us, then enter RX_WAIT_FALL. pin_oe SHALL stay 0 for the rest of the transaction.
REQ-019 pin_in SHALL pass through a 2-flop synchronizer. A falling edge is sync_prev=1 and sync_now=0.
REQ-020 In RX_WAIT_FALL, a falling edge SHALL enter RX_SAMPLE and restart the bit counter.
REQ-021 RX_SAMPLE SHALL sample the synchronized line exactly 2*CYCLES_PER_US cycles after the detected falling edge. It SHALL then shift the sample in: rx_data <= {rx_data[30:0], sample}.
REQ-022 After the sample, RX_WAIT_RISE SHALL wait for the line to read 1.
- If bits received = rx_len, go to FINISH.
- Otherwise go to RX_WAIT_FALL.
REQ-023 The gap timer SHALL count from entry into RX_WAIT_FALL and from entry into RX_WAIT_RISE.
- If it reaches TIMEOUT_US*CYCLES_PER_US, pulse timeout, clear busy and return to IDLE.
- rx_data SHALL then hold the partial bits received.
- done SHALL NOT pulse on this path.
REQ-024 FINISH SHALL pulse done for one cycle and return to IDLE. busy SHALL fall in the same cycle that done is asserted.
REQ-025 If rx_len is 0 or greater than 32, it SHALL be treated as 32.
REQ-026 done and timeout SHALL never be asserted in the same cycle.

Reset
REQ-027 When PRESERN=0 at a rising edge, the next cycle SHALL have:
- state = IDLE;
- pin_oe = 0, busy = 0, done = 0, timeout = 0;
- rx_data = 0, all counters = 0, both synchronizer flops = 1.
REQ-028 Reset asserted mid-transaction SHALL release the line (pin_oe=0) at that same edge. No done or timeout pulse SHALL follow.

Structure
REQ-029 Package n64_pkg SHALL hold the FSM state encodings and the low-phase durations (1 us, 3 us) expressed as multipliers of CYCLES_PER_US.
REQ-030 The synchronizer and falling-edge detect SHALL be one sub-module, n64_pin_sync. The tristate driver on fab_pin SHALL stay outside this block.

Verification
REQ-031 The bench SHALL use CYCLES_PER_US=10 and model the controller with an open-drain pull-up.
REQ-032 Scenario: cmd_byte=0x01 -> pin_oe shows seven 30-low/10-high symbols, one 10-low/30-high symbol, then a stop of 10 low / 20 high; first low at start+1 cycle.
REQ-033 Scenario: model replies 0x1234ABCD, rx_len=32 -> done pulses once, rx_data=0x1234ABCD, busy=0 on the cycle after done.
REQ-034 Scenario: cmd 0x00, rx_len=24, reply 0x050002 -> rx_data=0x00050002.
REQ-035 Scenario: no reply -> timeout pulses 1000 cycles after TX_STOP ends; rx_data=0; done never asserted.
REQ-036 Scenario: start pulsed again while busy -> ignored; pin_oe waveform identical to the single-start case.
REQ-037 Scenario: PRESERN=0 during bit 3 of TX -> pin_oe=0 and busy=0 on the next cycle; a start after release begins a clean transaction.
